// File: rtl/connect4_pkg.sv
// Shared command and lockout-state types for the button input path.
package connect4_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_LEFT  = 2'd1,
    CMD_RIGHT = 2'd2,
    CMD_DROP  = 2'd3
  } cmd_t;

  typedef enum logic {
    READY  = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Fixed priority: DROP beats LEFT beats RIGHT.
  function automatic cmd_t arb_pick(input logic l, input logic r, input logic d);
    if (d)      return CMD_DROP;
    else if (l) return CMD_LEFT;
    else if (r) return CMD_RIGHT;
    else        return CMD_NONE;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// First-word-fall-through FIFO. Fullness is judged before a same-cycle pop,
// so a push into a full FIFO is refused even while it drains.
module cmd_fifo
  import connect4_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = cmd_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     dout
);

  localparam int AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    occ_q, occ_d;
  logic           do_push, do_pop;

  assign full    = (occ_q == (AW+1)'(DEPTH));
  assign empty   = (occ_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? T'(0) : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    occ_d    = occ_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: the output is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/button_cmd_arbiter.sv
// Arbitrates debounced button pulses, applies a post-accept lockout and
// queues accepted moves for the game FSM; tracks lost presses for debug.
module button_cmd_arbiter
  import connect4_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             left_pulse,
  input  logic             right_pulse,
  input  logic             drop_pulse,
  output logic             cmd_valid,
  output logic [1:0]       cmd_code,
  input  logic             cmd_ready,
  input  logic             clr_stats,
  output logic             overflow,
  output logic [CNT_W-1:0] dropped_cnt
);

  localparam int LW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

  lock_state_t      state_q, state_d;
  logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  cmd_t             cand, fifo_dout;
  logic             fifo_full, fifo_empty, push, lost, ovf_evt;
  logic [1:0]       n_pulse, losers, inc;
  logic [CNT_W-1:0] base;
  logic [CNT_W:0]   sum;

  always_comb begin
    cand       = arb_pick(left_pulse, right_pulse, drop_pulse);
    n_pulse    = {1'b0, left_pulse} + {1'b0, right_pulse} + {1'b0, drop_pulse};
    losers     = (n_pulse != 2'd0) ? n_pulse - 2'd1 : 2'd0;
    push       = 1'b0;
    lost       = 1'b0;
    ovf_evt    = 1'b0;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      READY: begin
        if (en && cand != CMD_NONE) begin
          if (fifo_full) begin
            lost    = 1'b1;
            ovf_evt = 1'b1;
          end else begin
            push       = 1'b1;
            lock_cnt_d = LW'(LOCKOUT_CYCLES);
            if (LOCKOUT_CYCLES > 0) state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        // Counter runs regardless of en so the window is wall-clock based.
        lock_cnt_d = lock_cnt_q - 1'b1;
        if (lock_cnt_q == LW'(1)) state_d = READY;
        if (en && cand != CMD_NONE) lost = 1'b1;
      end
      default: state_d = READY;
    endcase

    inc        = en ? losers + {1'b0, lost} : 2'd0;
    base       = clr_stats ? '0 : drop_cnt_q;
    sum        = {1'b0, base} + (CNT_W+1)'(inc);
    drop_cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    ovf_d      = (clr_stats ? 1'b0 : ovf_q) | ovf_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= READY;
      lock_cnt_q <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  cmd_fifo #(.DEPTH(DEPTH), .T(cmd_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (cand),
    .pop   (cmd_ready),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign cmd_valid   = !fifo_empty;
  assign cmd_code    = fifo_dout;
  assign overflow    = ovf_q;
  assign dropped_cnt = drop_cnt_q;

endmodule

// File: tb/tb_button_cmd_arbiter.sv
// Two instances (lockout 16 and lockout 0) share stimulus; each is checked
// every cycle against a queue-based model plus literal vectors for corners.
module tb_button_cmd_arbiter;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, lp, rp, dp, rdy, clr;
  logic a_valid, b_valid, a_ovf, b_ovf;
  logic [1:0] a_code, b_code;
  logic [CNT_W-1:0] a_cnt, b_cnt;

  button_cmd_arbiter #(.DEPTH(DEPTH), .LOCKOUT_CYCLES(16), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst(rst), .en(en), .left_pulse(lp), .right_pulse(rp), .drop_pulse(dp),
    .cmd_valid(a_valid), .cmd_code(a_code), .cmd_ready(rdy), .clr_stats(clr),
    .overflow(a_ovf), .dropped_cnt(a_cnt));

  button_cmd_arbiter #(.DEPTH(DEPTH), .LOCKOUT_CYCLES(0), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst(rst), .en(en), .left_pulse(lp), .right_pulse(rp), .drop_pulse(dp),
    .cmd_valid(b_valid), .cmd_code(b_code), .cmd_ready(rdy), .clr_stats(clr),
    .overflow(b_ovf), .dropped_cnt(b_cnt));

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: queue of command codes, last-accept time for lockout.
  int mq [2][$];
  int m_last [2];
  bit m_lv [2];
  int m_cnt [2];
  bit m_ovf [2];
  int lock_len [2] = '{16, 0};
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void model_step(input int i);
    int n, cand, lost, ov;
    bit full, locked;
    if (rst) begin
      mq[i].delete();
      m_lv[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
      return;
    end
    n = int'(lp) + int'(rp) + int'(dp);
    cand = dp ? 3 : lp ? 1 : rp ? 2 : 0;
    full = (mq[i].size() == DEPTH);
    lost = 0; ov = 0;
    if (rdy && mq[i].size() > 0) void'(mq[i].pop_front());
    if (en && n > 0) begin
      lost = n - 1;
      locked = m_lv[i] && (cyc - m_last[i] <= lock_len[i]);
      if (locked) lost++;
      else if (full) begin lost++; ov = 1; end
      else begin mq[i].push_back(cand); m_last[i] = cyc; m_lv[i] = 1; end
    end
    m_cnt[i] = (clr ? 0 : m_cnt[i]) + lost;
    if (m_cnt[i] > CMAX) m_cnt[i] = CMAX;
    m_ovf[i] = (clr ? 1'b0 : m_ovf[i]) | ov[0];
  endfunction

  function automatic int model_pack(input int i);
    int v, c;
    v = (mq[i].size() > 0) ? 1 : 0;
    c = v ? mq[i][0] : 0;
    return (v << 11) | (c << 9) | (int'(m_ovf[i]) << 8) | m_cnt[i];
  endfunction

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    cyc++;
    #1;
    chk("model_a", {20'd0, a_valid, a_code, a_ovf, a_cnt}, model_pack(0));
    chk("model_b", {20'd0, b_valid, b_code, b_ovf, b_cnt}, model_pack(1));
  endtask

  task automatic drive(input logic r_, e_, l_, ri_, d_, rd_, c_);
    rst = r_; en = e_; lp = l_; rp = ri_; dp = d_; rdy = rd_; clr = c_;
  endtask

  typedef struct {
    logic rst, en, l, r, d, rdy, clr;
    logic v; logic [1:0] code; int cnt; logic ovf;
  } vec_t;

  vec_t tbl [12];

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    //            rst en l  r  d  rdy clr  v  code cnt ovf
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,0,1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,2'd1,0,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,2'd1,0,1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,2'd0,0,1'b0};
    tbl[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,0,1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,2'd3,1,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,2'd0,1,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,2'd0,2,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1, 1'b0,2'd0,3,1'b0};
    tbl[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,2'd0,0,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,0,1'b0};

    #2;
    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].rst, tbl[k].en, tbl[k].l, tbl[k].r, tbl[k].d, tbl[k].rdy, tbl[k].clr);
      step();
      chk($sformatf("vec%0d_valid", k), a_valid, tbl[k].v);
      chk($sformatf("vec%0d_code", k), a_code, tbl[k].code);
      chk($sformatf("vec%0d_cnt", k), a_cnt, tbl[k].cnt);
      chk($sformatf("vec%0d_ovf", k), a_ovf, tbl[k].ovf);
    end

    // Lockout window: right at 0, 8, 16, 17 after reset.
    drive(1, 0, 0, 0, 0, 0, 0); step();
    for (int k = 0; k < 18; k++) begin
      drive(0, 1, 0, (k == 0 || k == 8 || k == 16 || k == 17), 0, 0, 0);
      step();
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("lock_a_cnt", a_cnt, 2);
    chk("lock_a_valid", a_valid, 1);
    chk("lock_a_code", a_code, 2);
    chk("lock_b_cnt", b_cnt, 0);
    drive(0, 1, 0, 0, 0, 1, 0); step();
    chk("lock_a_second", a_valid, 1);
    step();
    chk("lock_a_drained", a_valid, 0);

    // Overflow on zero-lockout instance, then stats clear with queue intact.
    drive(1, 0, 0, 0, 0, 0, 0); step();
    for (int k = 0; k < 6; k++) begin drive(0, 1, 0, 0, 1, 0, 0); step(); end
    chk("ovf_b_valid", b_valid, 1);
    chk("ovf_b_code", b_code, 3);
    chk("ovf_b_cnt", b_cnt, 2);
    chk("ovf_b_flag", b_ovf, 1);
    chk("ovf_a_cnt", a_cnt, 5);
    drive(0, 1, 0, 0, 0, 0, 1); step();
    chk("clr_b_flag", b_ovf, 0);
    chk("clr_b_cnt", b_cnt, 0);
    chk("clr_b_valid", b_valid, 1);
    // Full, popping, and a new pulse in the same cycle: write still refused.
    drive(0, 1, 1, 0, 0, 1, 0); step();
    chk("fullpop_b_flag", b_ovf, 1);
    chk("fullpop_b_cnt", b_cnt, 1);
    chk("fullpop_a_valid", a_valid, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0, 1, 0); step();
      chk($sformatf("drain_b_%0d", k), b_valid, (k < 2));
    end

    // Reset mid-operation discards the queue; a later pulse is accepted.
    drive(1, 0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 1, 0, 0); step();
    drive(0, 1, 1, 0, 0, 0, 0); step();
    chk("pre_rst_b_valid", b_valid, 1);
    drive(1, 1, 0, 0, 0, 0, 0); step();
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_code", b_code, 0);
    drive(0, 1, 0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 1, 0, 0, 0); step();
    chk("post_rst_a_code", a_code, 2);
    chk("post_rst_b_code", b_code, 2);

    // Saturation of dropped_cnt.
    drive(1, 0, 0, 0, 0, 0, 0); step();
    for (int k = 0; k < 120; k++) begin drive(0, 1, 1, 1, 1, 0, 0); step(); end
    chk("sat_a_cnt", a_cnt, CMAX);
    chk("sat_b_cnt", b_cnt, CMAX);
    chk("sat_a_ovf", a_ovf, 1);

    // Randomised traffic against the model.
    drive(1, 0, 0, 0, 0, 0, 0); step();
    for (int k = 0; k < 800; k++) begin
      drive(($urandom_range(99) == 0), ($urandom_range(9) != 0),
            ($urandom_range(4) == 0), ($urandom_range(4) == 0), ($urandom_range(4) == 0),
            $urandom_range(1), ($urandom_range(19) == 0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
